heartbeat_monitor: RTL and testbench

Supervisor that consumes a periodic heartbeat level signal (the `heartbeat` generator's `o_heartbeat`, or an off-board heartbeat pin), measures its rising-edge period in clock cycles, and raises a sticky fault when beats stop or arrive too early. It sits directly downstream of the heartbeat generator and feeds status LEDs and the board health register.

---
 rtl/heartbeat_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_heartbeat_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// heartbeat_monitor
//
// Supervises a periodic heartbeat level signal. The input is synchronised,
// its rising edges are detected, and the rising-to-rising period is measured
// in clock cycles. A sticky fault is raised when beats stop (timeout) or
// arrive too early. i_clear drops the fault and restarts monitoring.
//
// Optional feature macro: HB_MON_STATS_EN
//   When defined, adds o_beat_count (legal RUN beats) and o_fault_count
//   (FAULT entries). Both saturate and are cleared by reset only.
// -----------------------------------------------------------------------------
module heartbeat_monitor #(
  parameter int unsigned MIN_PERIOD  = 11_000_000,  // smallest legal period
  parameter int unsigned MAX_PERIOD  = 13_000_000,  // largest legal period
  parameter int unsigned SYNC_STAGES = 2            // synchroniser depth, >= 2
) (
  input  logic        clock,
  input  logic        reset,            // asynchronous, active low
  input  logic        i_heartbeat,      // may be asynchronous to clock
  input  logic        i_clear,          // synchronous fault clear / restart
  output logic        o_alive,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic [31:0] o_period,
  output logic        o_period_valid
`ifdef HB_MON_STATS_EN
  ,
  output logic [15:0] o_beat_count,
  output logic [7:0]  o_fault_count
`endif
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_TIMEOUT = 2'b01,
    FC_EARLY   = 2'b10
  } fault_code_t;

  localparam logic [31:0] LP_MIN_PERIOD = MIN_PERIOD;
  localparam logic [31:0] LP_MAX_PERIOD = MAX_PERIOD;
  localparam logic [31:0] LP_CNT_SAT    = '1;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;       // synchroniser chain, [0] is first stage
  logic                   r_hb_d;       // last sync stage delayed one cycle
  logic                   w_edge;       // rising edge of synchronised heartbeat

  logic [31:0]            r_cnt;        // cycles since last edge / restart
  logic [31:0]            w_cnt_inc;    // r_cnt + 1, saturating
  logic                   w_timeout;    // no edge and period window exceeded
  logic                   w_early;      // measured period below minimum

  state_t                 r_state;
  state_t                 w_state_nxt;
  fault_code_t            r_code;
  fault_code_t            w_code_nxt;
  logic                   w_publish;    // an edge that updates o_period

  logic                   r_alive;
  logic                   r_fault;
  logic [31:0]            r_period;
  logic                   r_period_valid;

  // ---------------------------------------------------------------------------
  // Input synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  // Shift the raw heartbeat through the sync chain plus one delay flop.
  // NOTE: non-blocking (<=) for every flop so each register samples the
  // values that existed before the clock edge, independent of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_hb_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_heartbeat};
      r_hb_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hb_d;

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------
  // The measured period is the count at the edge plus one: the edge cycle
  // itself belongs to the interval being measured.
  assign w_cnt_inc = (r_cnt == LP_CNT_SAT) ? LP_CNT_SAT : (r_cnt + 32'd1);

  // A timeout fires in the first edge-less cycle where cnt+1 exceeds the
  // maximum, so a beat landing exactly on MAX_PERIOD is still legal.
  assign w_timeout = ~w_edge & (w_cnt_inc > LP_MAX_PERIOD);
  assign w_early   = (w_cnt_inc < LP_MIN_PERIOD);

  // Restart counting on every edge or clear, otherwise count up saturating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || w_edge) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Supervisor FSM
  // ---------------------------------------------------------------------------
  // State and fault-code registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_code  <= FC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // Next-state, next fault code and period-publish decision.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_publish   = 1'b0;

    if (i_clear) begin
      // Clear beats any fault event in the same cycle and restarts INIT.
      w_state_nxt = ST_INIT;
      w_code_nxt  = FC_NONE;
    end else begin
      case (r_state)
        ST_INIT: begin
          // First edge only arms monitoring; its period is meaningless.
          if (w_edge) begin
            w_state_nxt = ST_RUN;
          end else if (w_timeout) begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FC_TIMEOUT;
          end
        end

        ST_RUN: begin
          if (w_edge) begin
            w_publish = 1'b1;
            if (w_early) begin
              w_state_nxt = ST_FAULT;
              w_code_nxt  = FC_EARLY;
            end
          end else if (w_timeout) begin
            w_state_nxt = ST_FAULT;
            w_code_nxt  = FC_TIMEOUT;
          end
        end

        ST_FAULT: begin
          // Sticky: keep reporting periods but never rewrite the code.
          if (w_edge) begin
            w_publish = 1'b1;
          end
        end

        default: begin
          w_state_nxt = ST_INIT;
          w_code_nxt  = FC_NONE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Status flags follow the next state so they align with the state register;
  // the period and its valid pulse update together on a published edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alive        <= 1'b0;
      r_fault        <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_alive        <= (w_state_nxt == ST_RUN);
      r_fault        <= (w_state_nxt == ST_FAULT);
      r_period_valid <= w_publish;
      if (w_publish) begin
        r_period <= w_cnt_inc;
      end
    end
  end

  assign o_alive        = r_alive;
  assign o_fault        = r_fault;
  assign o_fault_code   = r_code;
  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;

`ifdef HB_MON_STATS_EN
  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
  logic [15:0] r_beat_count;
  logic [7:0]  r_fault_count;
  logic        w_legal_beat;
  logic        w_fault_enter;

  // A legal beat is an edge seen in RUN that keeps the FSM in RUN.
  assign w_legal_beat  = w_edge && (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_fault_enter = (r_state != ST_FAULT) && (w_state_nxt == ST_FAULT);

  // Saturating counters, deliberately untouched by i_clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_beat_count  <= '0;
      r_fault_count <= '0;
    end else begin
      if (w_legal_beat && (r_beat_count != 16'hFFFF)) begin
        r_beat_count <= r_beat_count + 16'd1;
      end
      if (w_fault_enter && (r_fault_count != 8'hFF)) begin
        r_fault_count <= r_fault_count + 8'd1;
      end
    end
  end

  assign o_beat_count  = r_beat_count;
  assign o_fault_count = r_fault_count;
`endif

endmodule

// File: tb/tb_heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// tb_heartbeat_monitor
//
// Self-checking bench for heartbeat_monitor with MIN_PERIOD=8, MAX_PERIOD=16,
// SYNC_STAGES=2. A timestamp-based reference model predicts every output each
// cycle; table vectors and hand-written sequences check spec-level results.
// Define HB_MON_STATS_EN to also exercise the statistics outputs.
// -----------------------------------------------------------------------------
module tb_heartbeat_monitor;

  localparam int MIN_P  = 8;
  localparam int MAX_P  = 16;
  localparam int SYNC_N = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hb    = 1'b0;
  logic        clr   = 1'b0;
  logic        alive;
  logic        fault;
  logic [1:0]  code;
  logic [31:0] period;
  logic        pvalid;
`ifdef HB_MON_STATS_EN
  logic [15:0] beat_count;
  logic [7:0]  fault_count;
`endif

  heartbeat_monitor #(
    .MIN_PERIOD (MIN_P),
    .MAX_PERIOD (MAX_P),
    .SYNC_STAGES(SYNC_N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_heartbeat   (hb),
    .i_clear       (clr),
    .o_alive       (alive),
    .o_fault       (fault),
    .o_fault_code  (code),
    .o_period      (period),
    .o_period_valid(pvalid)
`ifdef HB_MON_STATS_EN
    ,
    .o_beat_count  (beat_count),
    .o_fault_count (fault_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works from timestamps. Cycle k is the clock period that
  // ends at the k-th rising clock after reset release. A pin level applied
  // for cycle j is seen as an edge in cycle j+2 if the level one cycle earlier
  // was low. The period of an edge in cycle k is k minus the cycle of the last
  // edge/clear/reset.
  // ---------------------------------------------------------------------------
  typedef enum int {M_INIT, M_RUN, M_FAULT} mphase_t;

  int      mk;
  bit      pins[$];
  int      last_ref;
  mphase_t mph;
  int      mcode;
  longint  mperiod;
  bit      mvalid;
  int      mbeats;
  int      mfaults;
  int      valid_seen;

  function automatic bit pin_at(input int i);
    if (i < 1) return 1'b0;
    return pins[i-1];
  endfunction

  function automatic void model_reset();
    mk       = 0;
    pins.delete();
    last_ref = 0;
    mph      = M_INIT;
    mcode    = 0;
    mperiod  = 0;
    mvalid   = 1'b0;
    mbeats   = 0;
    mfaults  = 0;
  endfunction

  function automatic void model_step(input bit p, input bit c);
    bit     e;
    longint gap;
    mk++;
    pins.push_back(p);
    e      = pin_at(mk - 2) && !pin_at(mk - 3);
    gap    = longint'(mk - last_ref);
    mvalid = 1'b0;
    if (c) begin
      mph      = M_INIT;
      mcode    = 0;
      last_ref = mk;
    end else if (e) begin
      if (mph != M_INIT) begin
        mvalid  = 1'b1;
        mperiod = gap;
      end
      if (mph == M_INIT) begin
        mph = M_RUN;
      end else if (mph == M_RUN) begin
        if (gap < MIN_P) begin
          mph   = M_FAULT;
          mcode = 2;
          mfaults++;
        end else begin
          mbeats++;
        end
      end
      last_ref = mk;
    end else if (mph != M_FAULT && gap > MAX_P) begin
      mph   = M_FAULT;
      mcode = 1;
      mfaults++;
    end
  endfunction

  // Apply one cycle of inputs, advance the clock, compare against the model.
  task automatic step(input bit p, input bit c);
    logic [31:0] exp_period;
    logic [1:0]  exp_code;
    hb  = p;
    clr = c;
    @(posedge clock);
    #1;
    model_step(p, c);
    if (pvalid) valid_seen++;
    exp_period = mperiod[31:0];
    exp_code   = mcode[1:0];
    check("cycle_outputs", {alive, fault, code, period, pvalid},
          {(mph == M_RUN), (mph == M_FAULT), exp_code, exp_period, mvalid});
`ifdef HB_MON_STATS_EN
    check("cycle_stats", {beat_count, fault_count},
          {16'((mbeats > 65535) ? 65535 : mbeats), 8'((mfaults > 255) ? 255 : mfaults)});
`endif
  endtask

  // Hold reset for a few clocks, check reset values, release just after an edge.
  task automatic do_reset();
    hb    = 1'b0;
    clr   = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {alive, fault, code, period, pvalid}, 64'd0);
    reset = 1'b1;
    model_reset();
    valid_seen = 0;
  endtask

  // n rising edges spaced per cycles, high for the first half of each beat.
  task automatic beats(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < per; s++) step(s < per / 2, 1'b0);
    end
  endtask

  typedef struct {
    int          per;
    int          n;
    bit          e_alive;
    bit          e_fault;
    logic [1:0]  e_code;
    logic [31:0] e_period;
    int          e_valids;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // period, edges, alive, fault, code, last period, valid pulses
    tbl[0] = '{12, 5, 1'b1, 1'b0, 2'b00, 32'd12, 4};
    tbl[1] = '{8,  5, 1'b1, 1'b0, 2'b00, 32'd8,  4};
    tbl[2] = '{16, 5, 1'b1, 1'b0, 2'b00, 32'd16, 4};
    tbl[3] = '{7,  2, 1'b0, 1'b1, 2'b10, 32'd7,  1};
    tbl[4] = '{20, 2, 1'b0, 1'b1, 2'b01, 32'd20, 1};

    model_reset();

    // Table-driven steady beats and boundary periods.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      beats(tbl[v].per, tbl[v].n);
      check($sformatf("tbl%0d_status", v), {alive, fault, code},
            {tbl[v].e_alive, tbl[v].e_fault, tbl[v].e_code});
      check($sformatf("tbl%0d_period", v), period, tbl[v].e_period);
      check($sformatf("tbl%0d_valids", v), valid_seen, tbl[v].e_valids);
    end

    // No beat after reset: timeout exactly 17 cycles after release.
    do_reset();
    repeat (16) step(1'b0, 1'b0);
    check("no_beat_before_timeout", fault, 1'b0);
    step(1'b0, 1'b0);
    check("no_beat_timeout", {fault, code}, 3'b101);

    // Early beat: fault visible right after the edge cycle, not before.
    do_reset();
    beats(12, 2);
    for (int s = 0; s < 7; s++) step(s < 3, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("early_not_yet", fault, 1'b0);
    step(1'b1, 1'b0);
    check("early_fault", {fault, code, period}, {1'b1, 2'b10, 32'd7});

    // Beats stop after RUN, then a late edge keeps code 01.
    do_reset();
    beats(12, 2);
    repeat (7) step(1'b0, 1'b0);
    check("stop_before_timeout", {alive, fault}, 2'b10);
    step(1'b0, 1'b0);
    check("stop_timeout", {fault, code}, 3'b101);
    repeat (3) step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    check("late_edge", {pvalid, period, code}, {1'b1, 32'd23, 2'b01});

    // Clear in the same cycle as the timeout, then recover.
    do_reset();
    repeat (16) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("clear_beats_timeout", {alive, fault, code}, 4'b0000);
    beats(12, 3);
    check("clear_recover", {alive, fault}, 2'b10);

    // Asynchronous reset in the middle of RUN.
    do_reset();
    beats(12, 3);
    check("pre_reset_run", {alive, period}, {1'b1, 32'd12});
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {alive, fault, code, period, pvalid}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();

`ifdef HB_MON_STATS_EN
    // Statistics: 3 legal beats, then one more plus an early beat.
    do_reset();
    beats(12, 4);
    check("stats_beats3", beat_count, 16'd3);
    beats(7, 2);
    check("stats_after_fault", {beat_count, fault_count}, {16'd4, 8'd1});
    step(1'b0, 1'b1);
    check("stats_survive_clear", {fault, beat_count, fault_count}, {1'b0, 16'd4, 8'd1});
`endif

    // Randomised beats, gaps and clears checked against the model.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int per;
      int hw;
      int cpos;
      per  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 40))
                                         : int'($urandom_range(5, 20));
      hw   = int'($urandom_range(1, per - 1));
      cpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, per - 1)) : -1;
      for (int s = 0; s < per; s++) step(s < hw, s == cpos);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
